// File: rtl/pipe_chain_pkg.sv
// Shared helpers for pipe_chain: occupancy counter width and the bubble payload word.
// The bubble word is loaded only when PIPE_CHAIN_BUBBLE_ZERO_EN is defined.
package pipe_chain_pkg;

    function automatic int occ_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    // MIPS NOP: all control fields (RegWrite, MemWrite, ...) cleared.
    localparam logic [63:0] NOP_WORD = '0;

endpackage

// File: rtl/pipe_chain_slot.sv
// One pipeline stage: valid bit plus payload register with hold / load control.
// With PIPE_CHAIN_BUBBLE_ZERO_EN defined, a stage whose next valid is 0 loads NOP_WORD.
module pipe_chain_slot
    import pipe_chain_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             hold_i,
    input  logic             load_valid_i,
    input  logic [WIDTH-1:0] load_data_i,
    output logic             valid_o,
    output logic             valid_nxt_o,
    output logic [WIDTH-1:0] data_o
);

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q,  data_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (hold_i) begin
            // Only an effectively valid entry can hold, so it stays valid.
            valid_d = 1'b1;
        end else begin
            valid_d = load_valid_i;
            data_d  = load_data_i;
        end
`ifdef PIPE_CHAIN_BUBBLE_ZERO_EN
        if (!valid_d) begin
            data_d = WIDTH'(NOP_WORD);
        end
`endif
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o     = valid_q;
    assign valid_nxt_o = valid_d;
    assign data_o      = data_q;

endmodule

// File: rtl/pipe_chain.sv
// DEPTH-stage pipeline register chain with stall back-pressure, flush and bubble collapse.
// Optional macro PIPE_CHAIN_BUBBLE_ZERO_EN: invalid stages load the NOP word instead of stale data.
module pipe_chain
    import pipe_chain_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      in_valid_i,
    input  logic [WIDTH-1:0]          in_data_i,
    output logic                      in_ready_o,
    input  logic [DEPTH-1:0]          stall_i,
    input  logic [DEPTH-1:0]          flush_i,
    output logic [DEPTH-1:0]          stage_valid_o,
    output logic [DEPTH*WIDTH-1:0]    stage_data_o,
    output logic                      out_valid_o,
    output logic [WIDTH-1:0]          out_data_o,
    input  logic                      out_ready_i,
    output logic [occ_w(DEPTH)-1:0]   occupancy_o
);

    localparam int OCC_W = occ_w(DEPTH);

    logic [DEPTH-1:0] ev;
    logic [DEPTH-1:0] blk;
    logic [DEPTH-1:0] load_valid;
    logic [DEPTH-1:0] valid_nxt;
    logic [OCC_W-1:0] occ_q, occ_d;

    // Block chain ripples from the output back to stage 0; flushed or empty stages never block.
    always_comb begin
        ev         = stage_valid_o & ~flush_i;
        blk        = '0;
        load_valid = '0;
        blk[DEPTH-1] = ev[DEPTH-1] & (stall_i[DEPTH-1] | ~out_ready_i);
        for (int k = DEPTH - 2; k >= 0; k--) begin
            blk[k] = ev[k] & (stall_i[k] | blk[k+1]);
        end
        load_valid[0] = in_valid_i;
        for (int k = 1; k < DEPTH; k++) begin
            load_valid[k] = ev[k-1] & ~blk[k-1];
        end
    end

    for (genvar k = 0; k < DEPTH; k++) begin : g_slot
        logic [WIDTH-1:0] src_data;
        if (k == 0) begin : g_head
            assign src_data = in_data_i;
        end else begin : g_body
            assign src_data = stage_data_o[(k-1)*WIDTH +: WIDTH];
        end

        pipe_chain_slot #(
            .WIDTH(WIDTH)
        ) u_slot (
            .clk_i        (clk_i),
            .rst_i        (rst_i),
            .hold_i       (blk[k]),
            .load_valid_i (load_valid[k]),
            .load_data_i  (src_data),
            .valid_o      (stage_valid_o[k]),
            .valid_nxt_o  (valid_nxt[k]),
            .data_o       (stage_data_o[k*WIDTH +: WIDTH])
        );
    end

    always_comb begin
        occ_d = '0;
        for (int k = 0; k < DEPTH; k++) begin
            occ_d = occ_d + OCC_W'(valid_nxt[k]);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_d;
        end
    end

    assign in_ready_o  = ~blk[0];
    assign out_valid_o = stage_valid_o[DEPTH-1];
    assign out_data_o  = stage_data_o[(DEPTH-1)*WIDTH +: WIDTH];
    assign occupancy_o = occ_q;

endmodule

// File: tb/tb_pipe_chain.sv
// Directed bench for pipe_chain (DEPTH=4, WIDTH=32) with an in-order scoreboard on the output.
module tb_pipe_chain;

    localparam int WIDTH = 32;
    localparam int DEPTH = 4;

    logic                   clk = 1'b0;
    logic                   rst_i;
    logic                   in_valid_i;
    logic [WIDTH-1:0]       in_data_i;
    logic                   in_ready_o;
    logic [DEPTH-1:0]       stall_i;
    logic [DEPTH-1:0]       flush_i;
    logic [DEPTH-1:0]       stage_valid_o;
    logic [DEPTH*WIDTH-1:0] stage_data_o;
    logic                   out_valid_o;
    logic [WIDTH-1:0]       out_data_o;
    logic                   out_ready_i;
    logic [2:0]             occupancy_o;

    int n_vec = 0;
    int n_err = 0;
    bit sb_en = 1'b0;
    logic [WIDTH-1:0] sb_q[$];

    always #5 clk = ~clk;

    pipe_chain #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .in_valid_i    (in_valid_i),
        .in_data_i     (in_data_i),
        .in_ready_o    (in_ready_o),
        .stall_i       (stall_i),
        .flush_i       (flush_i),
        .stage_valid_o (stage_valid_o),
        .stage_data_o  (stage_data_o),
        .out_valid_o   (out_valid_o),
        .out_data_o    (out_data_o),
        .out_ready_i   (out_ready_i),
        .occupancy_o   (occupancy_o)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Sample handshakes just before the edge, then advance to 1 time unit after it.
    task automatic tick();
        logic [WIDTH-1:0] exp_d;
        #1;
        if (sb_en) begin
            if (in_valid_i && in_ready_o) sb_q.push_back(in_data_i);
            if (out_valid_o && out_ready_i && !flush_i[DEPTH-1] && !stall_i[DEPTH-1]) begin
                if (sb_q.size() == 0) begin
                    chk("sb_underflow", 128'(sb_q.size()), 128'd1);
                end else begin
                    exp_d = sb_q.pop_front();
                    chk("sb_out", 128'(out_data_o), 128'(exp_d));
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int g = 0;
        while (sb_q.size() != 0 && g < 16) begin
            tick();
            g++;
        end
        chk("drain_done", 128'(sb_q.size()), 128'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        rst_i       = 1'b1;
        in_valid_i  = 1'b0;
        in_data_i   = '0;
        stall_i     = '0;
        flush_i     = '0;
        out_ready_i = 1'b0;
        #12;
        chk("rst_valid", 128'(stage_valid_o), 128'd0);
        chk("rst_data",  stage_data_o, 128'd0);
        chk("rst_occ",   128'(occupancy_o), 128'd0);
        chk("rst_ovalid", 128'(out_valid_o), 128'd0);
        chk("rst_iready", 128'(in_ready_o), 128'd1);
        rst_i = 1'b0;

        // Unstalled stream 1..8
        sb_en = 1'b1;
        out_ready_i = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            in_valid_i = 1'b1;
            in_data_i  = WIDTH'(i);
            tick();
            if (i == 3) chk("latency_early", 128'(out_valid_o), 128'd0);
            if (i == 4) chk("latency_first", 128'(out_data_o), 128'h1);
            if (i >= 4) begin
                chk("stream_ovalid", 128'(out_valid_o), 128'd1);
                chk("stream_occ", 128'(occupancy_o), 128'd4);
            end
        end
        in_valid_i = 1'b0;
        drain();
        chk("stream_empty_occ", 128'(occupancy_o), 128'd0);

        // Fill with consumer not ready, hold frozen, then release with stall on stage 1
        out_ready_i = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            in_valid_i = 1'b1;
            in_data_i  = WIDTH'(i);
            tick();
        end
        in_data_i = 32'h5;
        for (int j = 0; j < 3; j++) begin
            #1;
            chk("full_iready", 128'(in_ready_o), 128'd0);
            chk("full_frozen", stage_data_o, 128'h00000001_00000002_00000003_00000004);
            chk("full_occ", 128'(occupancy_o), 128'd4);
            tick();
        end
        in_valid_i  = 1'b0;
        out_ready_i = 1'b1;
        stall_i     = 4'b0010;
        tick();
        chk("stall1_valid", 128'(stage_valid_o), 128'b1011);
        chk("stall1_out", 128'(out_data_o), 128'h2);
        chk("stall1_s1", 128'(stage_data_o[63:32]), 128'h3);
        chk("stall1_s0", 128'(stage_data_o[31:0]), 128'h4);
        chk("stall1_occ", 128'(occupancy_o), 128'd3);
        stall_i = '0;
        drain();
        chk("stall1_empty", 128'(stage_valid_o), 128'd0);

        // Flush stages 0,1 while an input is presented
        sb_en = 1'b0;
        sb_q.delete();
        out_ready_i = 1'b0;
        in_valid_i  = 1'b1;
        in_data_i = 32'hC; tick();
        in_data_i = 32'hB; tick();
        in_data_i = 32'hA; tick();
        in_data_i   = 32'hD;
        out_ready_i = 1'b1;
        flush_i     = 4'b0011;
        tick();
        chk("flush_valid", 128'(stage_valid_o), 128'b1001);
        chk("flush_s3", 128'(out_data_o), 128'hC);
        chk("flush_s0", 128'(stage_data_o[31:0]), 128'hD);
        chk("flush_occ_in", 128'(occupancy_o), 128'd2);
        flush_i = '0;

        // Stall on an empty stage 2 must not back-pressure
        out_ready_i = 1'b0;
        stall_i     = 4'b0100;
        in_data_i   = 32'hE;
        #1;
        chk("stall_bubble_iready", 128'(in_ready_o), 128'd1);
        tick();

        // Asynchronous reset mid-stream
        #2;
        rst_i = 1'b1;
        #1;
        chk("arst_valid", 128'(stage_valid_o), 128'd0);
        chk("arst_occ", 128'(occupancy_o), 128'd0);
        chk("arst_data", stage_data_o, 128'd0);
        chk("arst_iready", 128'(in_ready_o), 128'd1);
        #1;
        rst_i      = 1'b0;
        stall_i    = '0;

        // Flush without an input presented
        in_data_i = 32'hC; tick();
        in_data_i = 32'hB; tick();
        in_data_i = 32'hA; tick();
        in_valid_i  = 1'b0;
        out_ready_i = 1'b1;
        flush_i     = 4'b0011;
        tick();
        chk("flush_occ_noin", 128'(occupancy_o), 128'd1);
        chk("flush_noin_valid", 128'(stage_valid_o), 128'b1000);
        flush_i = '0;
        tick();
        chk("flush_noin_empty", 128'(stage_valid_o), 128'd0);

        // Empty chain ignores every stall
        stall_i     = 4'b1111;
        out_ready_i = 1'b0;
        #1;
        chk("empty_stall_iready", 128'(in_ready_o), 128'd1);
        stall_i = '0;

        // Flush of stage 1 holding 0xDEAD with an empty stage 0 upstream
        in_valid_i = 1'b1;
        in_data_i  = 32'hDEAD;
        tick();
        in_valid_i = 1'b0;
        in_data_i  = 32'h1234;
        tick();
        chk("dead_loaded", 128'(stage_data_o[63:32]), 128'hDEAD);
        flush_i = 4'b0010;
        tick();
        flush_i = '0;
        chk("dead_flush_valid", 128'(stage_valid_o[1]), 128'd0);
`ifdef PIPE_CHAIN_BUBBLE_ZERO_EN
        chk("dead_flush_zero", 128'(stage_data_o[63:32]), 128'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pipe_chain.md
# pipe_chain

Parametrised pipeline-register chain with per-stage valid tracking, stall back-pressure, flush and bubble collapse. It generalises the fixed IF/ID, ID/EX, EX/MEM and MEM/WB latches of the MIPS core into one DEPTH-stage, WIDTH-bit block. The hazard unit drives its stall and flush vectors. The writeback side drains it through a ready/valid handshake.

## Interface
Parameters:
- WIDTH, 32, payload bits per stage
- DEPTH, 4, number of stages (≥1); stage 0 is the input side

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  reset, asynchronous, active-high
- in_valid_i  in  1  input payload present
- in_data_i  in  WIDTH  input payload
- in_ready_o  out  1  stage 0 can load this cycle
- stall_i  in  DEPTH  bit k: stage k must hold
- flush_i  in  DEPTH  bit k: kill stage k contents
- stage_valid_o  out  DEPTH  valid bit per stage
- stage_data_o  out  DEPTH*WIDTH  stage k at bits [k*WIDTH +: WIDTH]
- out_valid_o  out  1  equals stage_valid_o[DEPTH-1]
- out_data_o  out  WIDTH  last-stage payload
- out_ready_i  in  1  consumer accepts last stage
- occupancy_o  out  $clog2(DEPTH+1)  count of valid stages

## Operation
- Effective valid: ev[k] = valid[k] & ~flush_i[k]. A flushed entry no longer exists this cycle.
- Block chain, evaluated from the output backwards:
  - blk[DEPTH-1] = ev[DEPTH-1] & (stall_i[DEPTH-1] | ~out_ready_i)
  - blk[k] = ev[k] & (stall_i[k] | blk[k+1])
- Invalid stages never block (bubble collapse), even if stall_i[k] is asserted.
- in_ready_o = ~blk[0].
- Next state of stage k:
  - if blk[k]: hold; valid ← ev[k] (always 1), data unchanged
  - else, k>0: valid ← ev[k-1] & ~blk[k-1], data ← data[k-1]
  - else, k=0: valid ← in_valid_i, data ← in_data_i
- A stage that advances while its upstream stage holds receives a bubble (valid 0).
- Output transfer happens when out_valid_o & out_ready_i & ~flush_i[DEPTH-1] & ~stall_i[DEPTH-1].
- occupancy_o is a register updated with the popcount of next-state valid bits. It is never combinational from inputs.
- Flush has priority over stall on the same stage. Flush does not block upstream, so upstream may advance into the freed slot in the same cycle.
- Input accept when in_valid_i & in_ready_o. When in_ready_o=0 the input is not captured, and the driver must hold it.

## Timing
- Reset: all valid 0, all data 0, occupancy_o 0, out_valid_o 0, in_ready_o 1 (combinational from zero valids).
- Reset mid-operation clears everything immediately (asynchronous) with no partial drain. The first load happens on the first rising edge after rst_i deasserts.
- Latency with no stalls: an entry accepted at edge n appears on out_valid_o after edge n+DEPTH-1 (DEPTH edges of register delay counting the accept edge).
- Throughput: 1 entry per cycle when unstalled.
- in_ready_o depends combinationally on out_ready_i, stall_i and flush_i through the block chain (ripple path, DEPTH deep). It is permitted; the integrator must close timing.
- Full chain with out_ready_i=0: occupancy_o=DEPTH, in_ready_o=0.
- Empty chain: every stall_i is ignored and in_ready_o=1.

## Configuration
- PIPE_CHAIN_BUBBLE_ZERO_EN defined:
  - any stage whose next valid is 0 also loads data 0 (MIPS NOP encoding, RegWrite/MemWrite fields cleared)
  - applies to both bubbles and flushes
- Undefined: invalid stages keep stale data, for lower toggle power. Consumers must qualify with valid.

## Structure
- Package pipe_chain_pkg holds:
  - occupancy width function occ_w(depth) = $clog2(depth+1)
  - constant NOP_WORD = '0
- Natural sub-module: pipe_chain_slot (one valid+data register with hold/load/clear controls), instantiated DEPTH times by a generate loop.
- Block chain and popcount stay in the top.

## Test plan
- DEPTH=4, WIDTH=32, stream 0x1..0x8 with out_ready_i=1: out_data_o sequence 0x1..0x8, first at 4 edges after the first accept, no gaps, occupancy_o steady 4.
- Chain full, out_ready_i=0 for 3 cycles: in_ready_o=0, data frozen. Release: 0x1 drains next cycle.
- stall_i[1] for 1 cycle with stages 0..3 holding 0x4,0x3,0x2,0x1: stages 0,1 hold, stage 2 becomes a bubble, stage 3 outputs 0x2 next cycle.
- Stages 0..2 valid 0xA,0xB,0xC, stage 3 invalid, out_ready_i=1, flush_i=4'b0011 for one cycle:
  - next cycle stage 3 = 0xC, stages 1,2 invalid, stage 0 loads the new input
  - occupancy_o = 2 with an input presented, else 1
- stall_i[2] asserted while stage 2 is invalid: no back-pressure, in_ready_o stays 1.
- Build with PIPE_CHAIN_BUBBLE_ZERO_EN, flush stage 1 holding 0xDEAD: stage_data_o[1] reads 0 next cycle.
- rst_i pulsed mid-stream: stage_valid_o=0 and occupancy_o=0 immediately, before the next edge.
